// File: rtl/bus_pkg.sv
// Shared definitions for the valid/ready bus: state encoding, rw polarity,
// default widths and the saturating counter helper.
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} bus_tgt_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous word array with write enable and registered read data.
// Contents are deliberately not reset.
module bus_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_target.sv
// Memory-mapped bus target: captures one request, waits WAIT_CYCLES, then
// completes with a registered one-cycle ready pulse plus range error and counters.
module bus_mem_target
    import bus_pkg::*;
#(
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    bus_tgt_state_e    state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [15:0]       rd_count_q, rd_count_d;

    logic              in_range;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Memory access is issued in ACK so write and read data land on the same edge as ready.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign mem_we   = (state_q == ACK) && (rw_q == RW_WRITE) && in_range;
    assign mem_re   = (state_q == ACK) && (rw_q == RW_READ) && in_range;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    rw_d       = rw;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    wait_cnt_d = WAIT_L;
                    state_d    = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ready_d = 1'b1;
                state_d = IDLE;
                if (!in_range) begin
                    err_d = 1'b1;
                end else if (rw_q == RW_WRITE) begin
                    wr_count_d = sat_inc16(wr_count_q);
                end else begin
                    rvalid_d   = 1'b1;
                    rd_count_d = sat_inc16(rd_count_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            rw_q       <= RW_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    bus_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk_i   (clk),
        .wr_en_i (mem_we),
        .rd_en_i (mem_re),
        .addr_i  (addr_q[MEM_AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // The array's read register is not reset; gating keeps rdata at 0 outside read completions.
    assign ready    = ready_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;
    assign rdata    = rvalid_q ? mem_rdata : '0;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_bus_mem_target.sv
// Scoreboard bench for bus_mem_target: two instances (no wait states / DEPTH 128,
// and 3 wait states / DEPTH 256) driven by directed and random transfers.
module tb_bus_mem_target;

    localparam int DEPTH_A = 128;
    localparam int WAIT_A  = 0;
    localparam int DEPTH_B = 256;
    localparam int WAIT_B  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n, valid, rw;
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    wire  [1:0]  ready, rvalid, err;
    wire  [31:0] rdata [2];
    wire  [15:0] wrc   [2];
    wire  [15:0] rdc   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bus_mem_target #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .valid(valid[0]), .rw(rw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
        .err(err[0]), .wr_count(wrc[0]), .rd_count(rdc[0])
    );

    bus_mem_target #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .valid(valid[1]), .rw(rw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
        .err(err[1]), .wr_count(wrc[1]), .rd_count(rdc[1])
    );

    typedef struct {
        int          due;
        bit          rw;
        bit          err;
        bit          chk;
        logic [31:0] data;
        logic [15:0] wc;
        logic [15:0] rc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] mem_m [2][256];
    bit          known [2][256];
    int          wcm   [2];
    int          rcm   [2];

    function automatic int depth_of(int k);
        return (k == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic int wait_of(int k);
        return (k == 0) ? WAIT_A : WAIT_B;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: applied in issue order, result queued for the monitor.
    task automatic push_exp(int k, bit w, int a, logic [31:0] d);
        exp_t e;
        e.due  = cyc + 2 + wait_of(k);
        e.rw   = w;
        e.err  = (a >= depth_of(k));
        e.chk  = 1'b1;
        e.data = 32'h0;
        if (!e.err) begin
            if (w) begin
                mem_m[k][a] = d;
                known[k][a] = 1'b1;
                if (wcm[k] < 65535) wcm[k]++;
            end else begin
                e.data = mem_m[k][a];
                e.chk  = known[k][a];
                if (rcm[k] < 65535) rcm[k]++;
            end
        end
        e.wc = 16'(wcm[k]);
        e.rc = 16'(rcm[k]);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called just after a rising edge with the target idle.
    task automatic do_xfer(int k, bit w, int a, logic [31:0] d, bit hold);
        int n;
        bit done;
        valid[k] = 1'b1;
        rw[k]    = w;
        addr[k]  = 8'(a);
        wdata[k] = d;
        push_exp(k, w, a, d);
        n    = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[k]) done = 1'b1;
            else begin
                addr[k]  = 8'($urandom);
                wdata[k] = $urandom;
                rw[k]    = 1'($urandom);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL dut%0d timeout: no ready after %0d cycles, required within %0d", k, n, 2 + wait_of(k));
        end
        if (!hold) valid[k] = 1'b0;
    endtask

    task automatic check_zero(int k, string tag);
        check($sformatf("dut%0d %s ready", k, tag),  32'(ready[k]), 32'h0);
        check($sformatf("dut%0d %s rvalid", k, tag), 32'(rvalid[k]), 32'h0);
        check($sformatf("dut%0d %s err", k, tag),    32'(err[k]), 32'h0);
        check($sformatf("dut%0d %s rdata", k, tag),  rdata[k], 32'h0);
        check($sformatf("dut%0d %s wr_count", k, tag), 32'(wrc[k]), 32'h0);
        check($sformatf("dut%0d %s rd_count", k, tag), 32'(rdc[k]), 32'h0);
    endtask

    bit prev_rdy [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ready[k]) begin
                exp_t e;
                bit   have;
                check($sformatf("dut%0d pulse width", k), 32'(prev_rdy[k]), 32'h0);
                have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
                total++;
                if (!have) begin
                    bad++;
                    $display("FAIL dut%0d unexpected ready: got 1 expected 0 at cycle %0d", k, cyc);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("dut%0d latency", k), 32'(cyc), 32'(e.due));
                    check($sformatf("dut%0d rvalid", k), 32'(rvalid[k]), 32'(!e.rw && !e.err));
                    check($sformatf("dut%0d err", k), 32'(err[k]), 32'(e.err));
                    check($sformatf("dut%0d wr_count", k), 32'(wrc[k]), 32'(e.wc));
                    check($sformatf("dut%0d rd_count", k), 32'(rdc[k]), 32'(e.rc));
                    if (e.err || (!e.rw && e.chk))
                        check($sformatf("dut%0d rdata", k), rdata[k], e.data);
                end
            end
            prev_rdy[k] = ready[k];
        end
    end

    initial begin
        int a5 [5];
        logic [31:0] d5 [5];
        rst_n = 2'b11;
        valid = 2'b00;
        rw    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            addr[k]  = 8'h0;
            wdata[k] = 32'h0;
            wcm[k]   = 0;
            rcm[k]   = 0;
        end
        #1 rst_n = 2'b00;
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 2'b11;

        // Write then read, no wait states
        do_xfer(0, 1'b1, 'h10, 32'hDEADBEEF, 1'b0);
        do_xfer(0, 1'b0, 'h10, 32'h0, 1'b0);

        // Three wait states
        do_xfer(1, 1'b1, 'h20, 32'hCAFE0020, 1'b0);
        do_xfer(1, 1'b0, 'h20, 32'h0, 1'b0);

        // Out of range on the DEPTH=128 instance
        do_xfer(0, 1'b1, 'h00, 32'h11111111, 1'b0);
        do_xfer(0, 1'b1, 'h80, 32'h00000055, 1'b0);
        do_xfer(0, 1'b0, 'h00, 32'h0, 1'b0);

        // Back-to-back with valid held throughout
        for (int i = 0; i < 5; i++) begin
            a5[i] = 32 + i * 16 + int'($urandom_range(0, 15));
            d5[i] = $urandom;
        end
        for (int i = 0; i < 5; i++) do_xfer(0, 1'b1, a5[i], d5[i], 1'b1);
        for (int i = 0; i < 5; i++) do_xfer(0, 1'b0, a5[i], 32'h0, (i != 4));

        // Reset during WAIT of a write to 0x20: transfer is dropped
        valid[1] = 1'b1;
        rw[1]    = 1'b1;
        addr[1]  = 8'h20;
        wdata[1] = 32'hBAD0BAD0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n[1] = 1'b0;
        #1;
        check_zero(1, "abort");
        valid[1] = 1'b0;
        wcm[1] = 0;
        rcm[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        do_xfer(1, 1'b0, 'h20, 32'h0, 1'b0);

        // Random mix across both instances
        for (int i = 0; i < 40; i++) begin
            int  k;
            int  a;
            bit  w;
            int  gap;
            k = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255));
            w = 1'($urandom);
            if (!w && a < depth_of(k) && !known[k][a]) w = 1'b1;
            do_xfer(k, w, a, $urandom, 1'b0);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        // Saturation of the write counter
        dut_a.wr_count_q = 16'hFFFD;
        wcm[0] = 65533;
        for (int i = 0; i < 3; i++) do_xfer(0, 1'b1, i, $urandom, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
        check("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
